// File: rtl/pc_unit.sv
// Program counter with an internal next-PC selector: sequential, branch, jump,
// jump-register, stall and exception redirects, plus misaligned-target trap and fetch counter.
module pc_unit #(
   parameter int                WIDTH        = 32,
   parameter logic [WIDTH-1:0]  RESET_VECTOR = '0,
   parameter logic [31:0]       EXC_VECTOR   = 32'h0000_0080,
   parameter int                COUNT_W      = 32
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                stall,
   input  logic                branch_taken,
   input  logic [15:0]         branch_offset,
   input  logic                jump,
   input  logic [25:0]         jump_target,
   input  logic                jump_reg,
   input  logic [WIDTH-1:0]    reg_target,
   input  logic                exception,
   output logic [WIDTH-1:0]    pc,
   output logic [WIDTH-1:0]    pc_plus4,
   output logic [WIDTH-1:0]    epc,
   output logic [1:0]          exc_cause,
   output logic                flush,
   output logic [COUNT_W-1:0]  fetch_count
);

   localparam logic [WIDTH-1:0] EXC_PC      = WIDTH'(EXC_VECTOR);
   localparam logic [1:0]       CAUSE_EXT   = 2'd1;
   localparam logic [1:0]       CAUSE_ALIGN = 2'd2;

   // Word offset scaled to a byte displacement and sign-extended to the PC width.
   function automatic logic signed [WIDTH-1:0] branch_disp(input logic signed [15:0] off);
      return {{(WIDTH-18){off[15]}}, off, 2'b00};
   endfunction

   logic signed [WIDTH-1:0]  br_disp;
   logic [WIDTH-1:0]         br_target;
   logic [WIDTH-1:0]         j_target;
   logic                     misaligned;

   logic [WIDTH-1:0]         pc_nxt;
   logic [WIDTH-1:0]         epc_nxt;
   logic [1:0]               cause_nxt;
   logic                     flush_nxt;
   logic [COUNT_W-1:0]       count_nxt;

   assign pc_plus4   = pc + WIDTH'(4);
   assign br_disp    = branch_disp($signed(branch_offset));
   assign br_target  = pc_plus4 + $unsigned(br_disp);
   assign j_target   = {pc_plus4[WIDTH-1:28], jump_target, 2'b00};
   assign misaligned = |reg_target[1:0];

   always_comb begin
      pc_nxt    = pc_plus4;
      epc_nxt   = epc;
      cause_nxt = exc_cause;
      flush_nxt = 1'b0;
      count_nxt = fetch_count + COUNT_W'(1);
      if (exception) begin
         pc_nxt    = EXC_PC;
         epc_nxt   = pc;
         cause_nxt = CAUSE_EXT;
         flush_nxt = 1'b1;
      end else if (stall) begin
         pc_nxt    = pc;
         count_nxt = fetch_count;
      end else if (jump_reg) begin
         flush_nxt = 1'b1;
         if (misaligned) begin
            pc_nxt    = EXC_PC;
            epc_nxt   = pc;
            cause_nxt = CAUSE_ALIGN;
         end else begin
            pc_nxt    = reg_target;
         end
      end else if (jump) begin
         pc_nxt    = j_target;
         flush_nxt = 1'b1;
      end else if (branch_taken) begin
         pc_nxt    = br_target;
         flush_nxt = 1'b1;
      end
   end

   // Single register stage: redirected pc and its flush appear together one edge later.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pc          <= RESET_VECTOR;
         epc         <= '0;
         exc_cause   <= '0;
         flush       <= 1'b0;
         fetch_count <= '0;
      end else begin
         pc          <= pc_nxt;
         epc         <= epc_nxt;
         exc_cause   <= cause_nxt;
         flush       <= flush_nxt;
         fetch_count <= count_nxt;
      end
   end

endmodule

// File: doc/pc_unit.md
Name: pc_unit

Overview:
- Parametrised next-generation program counter for the 32-bit MIPS datapath.
- Replaces the plain "register inpc each clock" PC with an internal next-PC selector covering sequential, branch, jump, jump-register, stall and exception redirects.
- Provides an exception PC, a misaligned-target trap and a fetch counter.
- Sits at the front of the fetch path; pc drives instruction memory, pc_plus4 feeds the link register and branch adder.

Parameters:
- WIDTH, 32, PC width in bits; legal range 32..64.
- RESET_VECTOR, 0, pc value after reset; must be a multiple of 4.
- EXC_VECTOR, 32'h0000_0080, pc loaded on exception; zero-extended to WIDTH.
- COUNT_W, 32, width of fetch_count.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- stall  in  1  hold pc (pipeline hazard).
- branch_taken  in  1  conditional branch resolved taken.
- branch_offset  in  16  signed word offset (instruction imm16).
- jump  in  1  J/JAL redirect.
- jump_target  in  26  instruction index field.
- jump_reg  in  1  JR/JALR redirect.
- reg_target  in  WIDTH  register-sourced target.
- exception  in  1  external exception request.
- pc  out  WIDTH  current fetch address.
- pc_plus4  out  WIDTH  pc + 4, combinational.
- epc  out  WIDTH  address of the faulting fetch.
- exc_cause  out  2  0 = none, 1 = external, 2 = misaligned target.
- flush  out  1  registered pulse one cycle after any redirect.
- fetch_count  out  COUNT_W  count of cycles in which pc advanced.

Behaviour:
- Clock and reset: one clock, clk; reset is asynchronous and active-high.
- Reset values: pc = RESET_VECTOR, epc = 0, exc_cause = 0, flush = 0, fetch_count = 0. Reset asserted mid-operation overrides everything immediately; no redirect survives it.
- pc_plus4 = pc + 4, modulo 2^WIDTH.
- Next-PC candidate targets:
  - branch: pc_plus4 + (sign-extend(branch_offset) << 2), modulo 2^WIDTH.
  - jump: {pc_plus4[WIDTH-1:28], jump_target, 2'b00}.
  - jump_reg: reg_target.
- Per-edge priority, highest first:
  1. exception: pc <= EXC_VECTOR; epc <= pc; exc_cause <= 1; flush <= 1. Takes effect even when stall = 1.
  2. stall: pc, epc and exc_cause hold; flush <= 0; no count.
  3. jump_reg: if reg_target[1:0] != 0, trap: pc <= EXC_VECTOR, epc <= pc, exc_cause <= 2. Otherwise pc <= reg_target. flush <= 1 in both cases.
  4. jump: pc <= jump target; flush <= 1.
  5. branch_taken: pc <= branch target; flush <= 1.
  6. none: pc <= pc_plus4; flush <= 0.
- exc_cause holds until the next exception or trap overwrites it. It is not cleared by normal flow.
- Latency: one cycle from redirect input to new pc. flush is high during the cycle in which the redirected pc is presented.
- fetch_count increments on every edge that is not a stall, including redirect and exception edges. It wraps to 0 at 2^COUNT_W.
- Sequential wrap: pc = 2^WIDTH - 4 with no redirect gives pc = 0. No trap, no flag.
- Simultaneous jump, jump_reg and branch_taken: resolved strictly by the priority order above. Lower-priority inputs are ignored.
- Branch and jump targets are always word-aligned by construction. Only jump_reg can trap.

Test Plan:
- Reset and sequential flow: reset asserted, then released with RESET_VECTOR = 0 → pc reads 0, 4, 8, 12 on successive edges; fetch_count reads 0, 1, 2, 3; flush stays 0.
- Branch: pc = 0x100, branch_taken = 1, branch_offset = 0xFFFE → pc = 0xFC, flush = 1 for exactly one cycle.
- Jump and jump_reg together: pc = 0x4000_0010, jump = 1, jump_target = 0x0000040, jump_reg = 1, reg_target = 0x2000 → pc = 0x2000 (jump_reg wins). Repeat with only jump → pc = 0x4000_0100.
- Misaligned trap: pc = 0x200, jump_reg = 1, reg_target = 0x1002 → pc = 0x80, epc = 0x200, exc_cause = 2, flush = 1.
- Stall versus exception: stall = 1 for 3 edges at pc = 0x40 → pc and fetch_count unchanged. Then stall = 1 with exception = 1 → pc = 0x80, epc = 0x40, exc_cause = 1.
- Wrap and async reset: pc = 0xFFFF_FFFC, idle edge → pc = 0. Pulse reset between clock edges → pc = 0 and fetch_count = 0 immediately, without waiting for a clock edge.
